// File: rtl/round_key_sequencer_if.sv
// rtl/round_key_sequencer_if.sv - key-set load and round-key stream bundle for round_key_sequencer
// The producer side is master; the sequencer is slave.
interface round_key_sequencer_if #(
   parameter int NUM_ROUNDS = 10,
   parameter int RK_BITS    = 128,
   parameter int IDX_BITS   = 4
);
   logic                              loadValid;
   logic                              loadReady;
   logic [(NUM_ROUNDS+1)*RK_BITS-1:0] roundKeys;
   logic                              loadDecrypt;
   logic                              flush;
   logic                              replay;
   logic                              rkValid;
   logic                              rkReady;
   logic [RK_BITS-1:0]                rkData;
   logic [IDX_BITS-1:0]               rkIndex;
   logic                              rkLast;

   modport master (
      output loadValid, roundKeys, loadDecrypt, flush, replay, rkReady,
      input  loadReady, rkValid, rkData, rkIndex, rkLast
   );

   modport slave (
      input  loadValid, roundKeys, loadDecrypt, flush, replay, rkReady,
      output loadReady, rkValid, rkData, rkIndex, rkLast
   );
endinterface

// File: rtl/round_key_sequencer.sv
// rtl/round_key_sequencer.sv - holds one expanded key set and streams it one round key per handshake
// Optional ROUND_KEY_REPLAY_EN: keep the store after a stream and restart it on replay.
module round_key_sequencer #(
   parameter int NUM_ROUNDS = 10,
   parameter int RK_BITS    = 128,
   parameter int IDX_BITS   = 4
) (
   input  logic                   clock,
   input  logic                   resetN,
   round_key_sequencer_if.slave   sif
);
   typedef enum logic {IDLE, STREAM} state_t;

   localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_ROUNDS);

   state_t                             state_q, state_d;
   logic [IDX_BITS-1:0]                idx_q, idx_d;
   logic                               dec_q, dec_d;
   logic [NUM_ROUNDS:0][RK_BITS-1:0]   store_q, store_d;
   logic                               streaming;
   logic                               is_last;
   logic                               fire;

`ifdef ROUND_KEY_REPLAY_EN
   logic have_q, have_d;
`else
   logic replay_unused;
   assign replay_unused = sif.replay;
`endif

   assign streaming = (state_q == STREAM);
   assign is_last   = dec_q ? (idx_q == '0) : (idx_q == LAST_IDX);
   assign fire      = streaming & sif.rkReady;

   // Outputs are decoded from registered state so an async reset clears them immediately.
   assign sif.loadReady = ~streaming;
   assign sif.rkValid   = streaming;
   assign sif.rkData    = streaming ? store_q[idx_q] : '0;
   assign sif.rkIndex   = streaming ? idx_q : '0;
   assign sif.rkLast    = streaming & is_last;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      dec_d   = dec_q;
      store_d = store_q;
`ifdef ROUND_KEY_REPLAY_EN
      have_d  = have_q;
`endif
      case (state_q)
         IDLE: begin
            if (!sif.flush) begin
               if (sif.loadValid) begin
                  store_d = sif.roundKeys;
                  dec_d   = sif.loadDecrypt;
                  idx_d   = sif.loadDecrypt ? LAST_IDX : '0;
                  state_d = STREAM;
`ifdef ROUND_KEY_REPLAY_EN
                  have_d  = 1'b1;
               end else if (sif.replay && have_q) begin
                  idx_d   = dec_q ? LAST_IDX : '0;
                  state_d = STREAM;
`endif
               end
            end
         end
         STREAM: begin
            // A transfer in the flush cycle has already been handed over; only the stream ends.
            if (sif.flush) begin
               state_d = IDLE;
            end else if (fire) begin
               if (is_last) begin
                  state_d = IDLE;
               end else if (dec_q) begin
                  idx_d = idx_q - IDX_BITS'(1);
               end else begin
                  idx_d = idx_q + IDX_BITS'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         state_q <= IDLE;
         idx_q   <= '0;
         dec_q   <= 1'b0;
         store_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         dec_q   <= dec_d;
         store_q <= store_d;
      end
   end

`ifdef ROUND_KEY_REPLAY_EN
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         have_q <= 1'b0;
      end else begin
         have_q <= have_d;
      end
   end
`endif
endmodule
